// File: rtl/fetch_buffer.sv
// fetch_buffer: dual-issue instruction queue between fetch and decode.
// Circular buffer of DEPTH entries; up to two enqueues and two dequeues per cycle.
// Optional build macro FETCH_BUF_BYPASS_EN: when the queue is empty, fetch slots
// drive the decode outputs combinationally and only the unconsumed remainder is stored.
module fetch_buffer #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0001_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid1,
  input  logic                     enq_valid2,
  input  logic [31:0]              pcF1,
  input  logic [31:0]              pcF2,
  input  logic [31:0]              instrF1,
  input  logic [31:0]              instrF2,
  output logic                     enq_ready,
  input  logic [1:0]               deq_take,
  output logic                     validD1,
  output logic                     validD2,
  output logic [31:0]              pcD1,
  output logic [31:0]              pcD2,
  output logic [31:0]              instrD1,
  output logic [31:0]              instrD2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] mem_pc    [DEPTH];
  logic [31:0] mem_instr [DEPTH];

  logic [AW-1:0] head_p1, tail_p1;
  logic          bypass;
  logic [1:0]    n_enq, n_avail, deq_eff, wr_cnt;
  logic          out_v1, out_v2;
  logic [31:0]   out_pc1, out_pc2, out_in1, out_in2;
  logic [31:0]   wr_pc1, wr_pc2, wr_in1, wr_in2;

  assign head_p1   = head_q + AW'(1);
  assign tail_p1   = tail_q + AW'(1);
  assign enq_ready = (count_q <= READY_MAX);
  assign count     = count_q;

  // Output selection, dequeue clamping and next-state pointer/count arithmetic.
  always_comb begin
    n_enq = 2'd0;
    if (enq_ready && enq_valid1) n_enq = enq_valid2 ? 2'd2 : 2'd1;

    bypass = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
    bypass = (count_q == '0) && !flush && !rst;
`endif

    // Storage view by default; valids derived from the registered count.
    out_v1  = !flush && (count_q != '0);
    out_v2  = !flush && (count_q >= CW'(2));
    out_pc1 = mem_pc[head_q];
    out_pc2 = mem_pc[head_p1];
    out_in1 = mem_instr[head_q];
    out_in2 = mem_instr[head_p1];
    if (bypass) begin
      out_v1  = enq_valid1;
      out_v2  = enq_valid1 & enq_valid2;
      out_pc1 = pcF1;
      out_pc2 = pcF2;
      out_in1 = instrF1;
      out_in2 = instrF2;
    end

    n_avail = {1'b0, out_v1} + {1'b0, out_v2};
    deq_eff = (deq_take < n_avail) ? deq_take : n_avail;

    wr_cnt = n_enq;
    wr_pc1 = pcF1;
    wr_pc2 = pcF2;
    wr_in1 = instrF1;
    wr_in2 = instrF2;
    head_d  = head_q + AW'(deq_eff);
    count_d = count_q + CW'(n_enq) - CW'(deq_eff);
    if (bypass) begin
      // Entries consumed straight from the fetch slots never touch storage.
      wr_cnt  = n_enq - deq_eff;
      head_d  = head_q;
      count_d = CW'(wr_cnt);
      if (deq_eff == 2'd1) begin
        wr_pc1 = pcF2;
        wr_in1 = instrF2;
      end
    end
    tail_d = tail_q + AW'(wr_cnt);

    if (flush) begin
      wr_cnt  = 2'd0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end

    validD1 = out_v1;
    validD2 = out_v2;
    pcD1    = out_v1 ? out_pc1 : RESET_PC;
    pcD2    = out_v2 ? out_pc2 : RESET_PC;
    instrD1 = out_v1 ? out_in1 : NOP;
    instrD2 = out_v2 ? out_in2 : NOP;
  end

  // Pointer and occupancy registers; reset empties the queue immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only visible through valid-gated outputs.
  always_ff @(posedge clk) begin
    if (!rst && wr_cnt != 2'd0) begin
      mem_pc[tail_q]    <= wr_pc1;
      mem_instr[tail_q] <= wr_in1;
    end
    if (!rst && wr_cnt == 2'd2) begin
      mem_pc[tail_p1]    <= wr_pc2;
      mem_instr[tail_p1] <= wr_in2;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Testbench for fetch_buffer (DEPTH=8): vector table, corner sequences, reference-queue run.
module tb_fetch_buffer;

  localparam int          DEPTH = 8;
  localparam logic [31:0] RPC   = 32'h0001_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] KEY   = 32'h5A00_0000;
`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, enq_valid1, enq_valid2, enq_ready, validD1, validD2;
  logic [31:0] pcF1, pcF2, instrF1, instrF2, pcD1, pcD2, instrD1, instrD2;
  logic [1:0]  deq_take;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid1(enq_valid1), .enq_valid2(enq_valid2),
    .pcF1(pcF1), .pcF2(pcF2), .instrF1(instrF1), .instrF2(instrF2),
    .enq_ready(enq_ready), .deq_take(deq_take),
    .validD1(validD1), .validD2(validD2),
    .pcD1(pcD1), .pcD2(pcD2), .instrD1(instrD1), .instrD2(instrD2),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl, e1, e2;
    logic [31:0] p1, p2;
    logic [1:0]  tk;
    logic [3:0]  cnt;
    logic        rdy, v1, v2;
    logic [31:0] q1, q2;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic e1, input logic e2,
                       input logic [31:0] p1, input logic [31:0] p2, input logic [1:0] tk);
    flush = fl; enq_valid1 = e1; enq_valid2 = e2;
    pcF1 = p1; pcF2 = p2; instrF1 = p1 ^ KEY; instrF2 = p2 ^ KEY;
    deq_take = tk;
  endtask

  // Clock one edge with the current inputs, then return to idle inputs.
  task automatic step();
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] cnt, input logic rdy,
                           input logic v1, input logic v2,
                           input logic [31:0] q1, input logic [31:0] q2);
    chk({tag, ".count"}, {28'h0, count}, {28'h0, cnt});
    chk({tag, ".ready"}, {31'h0, enq_ready}, {31'h0, rdy});
    chk({tag, ".v1"}, {31'h0, validD1}, {31'h0, v1});
    chk({tag, ".v2"}, {31'h0, validD2}, {31'h0, v2});
    chk({tag, ".pc1"}, pcD1, v1 ? q1 : RPC);
    chk({tag, ".pc2"}, pcD2, v2 ? q2 : RPC);
    chk({tag, ".in1"}, instrD1, v1 ? (q1 ^ KEY) : NOP);
    chk({tag, ".in2"}, instrD2, v2 ? (q2 ^ KEY) : NOP);
  endtask

  vec_t        vecs[16];
  logic [31:0] mq[$];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'h10000, 32'h10004, 2'd0, 4'd2, 1'b1, 1'b1, 1'b1, 32'h10000, 32'h10004};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h10008, 32'h1000C, 2'd0, 4'd4, 1'b1, 1'b1, 1'b1, 32'h10000, 32'h10004};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h10010, 32'h10014, 2'd0, 4'd6, 1'b1, 1'b1, 1'b1, 32'h10000, 32'h10004};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h10018, 32'h1001C, 2'd0, 4'd8, 1'b0, 1'b1, 1'b1, 32'h10000, 32'h10004};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h10020, 32'h10024, 2'd0, 4'd8, 1'b0, 1'b1, 1'b1, 32'h10000, 32'h10004};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h10020, 32'h10024, 2'd2, 4'd6, 1'b1, 1'b1, 1'b1, 32'h10008, 32'h1000C};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,     32'h0,     2'd3, 4'd4, 1'b1, 1'b1, 1'b1, 32'h10010, 32'h10014};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h20000, 32'h20004, 2'd0, 4'd4, 1'b1, 1'b1, 1'b1, 32'h10010, 32'h10014};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h10020, 32'h0,     2'd1, 4'd4, 1'b1, 1'b1, 1'b1, 32'h10014, 32'h10018};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,     32'h0,     2'd2, 4'd2, 1'b1, 1'b1, 1'b1, 32'h1001C, 32'h10020};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h10024, 32'h10028, 2'd1, 4'd3, 1'b1, 1'b1, 1'b1, 32'h10020, 32'h10024};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h1002C, 32'h10030, 2'd0, 4'd5, 1'b1, 1'b1, 1'b1, 32'h10020, 32'h10024};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 32'h10034, 32'h10038, 2'd2, 4'd0, 1'b1, 1'b0, 1'b0, RPC, RPC};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,     32'h0,     2'd2, 4'd0, 1'b1, 1'b0, 1'b0, RPC, RPC};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h10040, 32'h0,     2'd0, 4'd1, 1'b1, 1'b1, 1'b0, 32'h10040, RPC};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,     32'h0,     2'd3, 4'd0, 1'b1, 1'b0, 1'b0, RPC, RPC};

    // Reset state held across clock edges.
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 4'd0, 1'b1, 1'b0, 1'b0, RPC, RPC);
    rst = 1'b0;

    // Table-driven vectors; the first enqueue lands on the first edge after reset.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].fl, vecs[i].e1, vecs[i].e2, vecs[i].p1, vecs[i].p2, vecs[i].tk);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].rdy, vecs[i].v1, vecs[i].v2,
                vecs[i].q1, vecs[i].q2);
      $display("vec%0d fl=%0d e1=%0d e2=%0d tk=%0d -> count=%0d rdy=%0d v=%0d%0d pc1=%h pc2=%h",
               i, vecs[i].fl, vecs[i].e1, vecs[i].e2, vecs[i].tk, count, enq_ready,
               validD1, validD2, pcD1, pcD2);
    end

    // Flush forces valids low in the same cycle.
    drive(1'b0, 1'b1, 1'b1, 32'h50000, 32'h50004, 2'd0);
    step();
    flush = 1'b1;
    #1;
    chk("flush_comb.v1", {31'h0, validD1}, 32'h0);
    chk("flush_comb.v2", {31'h0, validD2}, 32'h0);
    step();
    chk("flush_comb.count", {28'h0, count}, 32'h0);
    $display("flush same-cycle: count=%0d", count);

    // Empty-queue enqueue with same-cycle dequeue.
    drive(1'b0, 1'b1, 1'b1, 32'h30000, 32'h30004, 2'd2);
    #1;
    chk("empty_deq.v1", {31'h0, validD1}, {31'h0, BYP});
    chk("empty_deq.pc1", pcD1, BYP ? 32'h30000 : RPC);
    chk("empty_deq.pc2", pcD2, BYP ? 32'h30004 : RPC);
    step();
    chk("empty_deq.count", {28'h0, count}, BYP ? 32'd0 : 32'd2);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    step();
    drive(1'b0, 1'b1, 1'b1, 32'h30008, 32'h3000C, 2'd1);
    #1;
    chk("empty_take1.in1", instrD1, BYP ? (32'h30008 ^ KEY) : NOP);
    step();
    check_out("empty_take1", BYP ? 4'd1 : 4'd2, 1'b1, 1'b1, !BYP,
              BYP ? 32'h3000C : 32'h30008, 32'h3000C);
    $display("empty-queue dequeue: count=%0d pc1=%h", count, pcD1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    step();

    // Reference-queue run with random takes across pointer wrap, starting at count=3.
    begin
      logic [31:0] pcn;
      logic        e1, e2, acc;
      logic [1:0]  tk;
      int          sz, eff, av;
      pcn = 32'h60000;
      mq.delete();
      for (int i = 0; i < 40; i++) begin
        if (i == 0) begin
          e1 = 1'b1; e2 = 1'b1; tk = 2'd0;
        end else if (i == 1) begin
          e1 = 1'b1; e2 = 1'b0; tk = 2'd0;
        end else if (i == 2) begin
          e1 = 1'b1; e2 = 1'b1; tk = 2'd2;
        end else begin
          e1 = ($urandom_range(0, 3) != 0);
          e2 = 1'($urandom_range(0, 1));
          tk = 2'($urandom_range(0, 3));
        end
        sz  = mq.size();
        acc = ((DEPTH - sz) >= 2) && e1;
        if (BYP && sz == 0) begin
          if (acc) mq.push_back(pcn);
          if (acc && e2) mq.push_back(pcn + 4);
          av  = mq.size();
          eff = (int'(tk) < av) ? int'(tk) : av;
          for (int k = 0; k < eff; k++) void'(mq.pop_front());
        end else begin
          av  = (sz < 2) ? sz : 2;
          eff = (int'(tk) < av) ? int'(tk) : av;
          for (int k = 0; k < eff; k++) void'(mq.pop_front());
          if (acc) mq.push_back(pcn);
          if (acc && e2) mq.push_back(pcn + 4);
        end
        drive(1'b0, e1, e2, pcn, pcn + 4, tk);
        pcn = pcn + 8;
        step();
        check_out($sformatf("rq%0d", i), 4'(mq.size()), (DEPTH - mq.size()) >= 2,
                  mq.size() >= 1, mq.size() >= 2,
                  (mq.size() >= 1) ? mq[0] : RPC, (mq.size() >= 2) ? mq[1] : RPC);
        $display("rq%0d e1=%0d e2=%0d tk=%0d -> count=%0d pc1=%h pc2=%h",
                 i, e1, e2, tk, count, pcD1, pcD2);
      end
    end

    // Asynchronous reset mid-stream with four entries queued.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    step();
    drive(1'b0, 1'b1, 1'b1, 32'h70000, 32'h70004, 2'd0);
    step();
    drive(1'b0, 1'b1, 1'b1, 32'h70008, 32'h7000C, 2'd0);
    step();
    chk("pre_rst.count", {28'h0, count}, 32'd4);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_out("async_rst", 4'd0, 1'b1, 1'b0, 1'b0, RPC, RPC);
    $display("async reset: count=%0d v=%0d%0d pc1=%h", count, validD1, validD2, pcD1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 32'h40000, 32'h40004, 2'd0);
    step();
    check_out("post_rst", 4'd2, 1'b1, 1'b1, 1'b1, 32'h40000, 32'h40004);
    $display("post reset enqueue: count=%0d pc1=%h pc2=%h", count, pcD1, pcD2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk rises; rst asserted high clears state immediately, independent of clk.
REQ-002 Parameter: DEPTH, 8, queue entries; power of two, minimum 4.
REQ-003 Parameter: RESET_PC, 32'h0001_0000, value driven on pcD1/pcD2 while the matching valid is low.
REQ-004 Port: clk  input  1  system clock.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: flush  input  1  redirect; discard all queued instructions.
REQ-007 Port: enq_valid1 / enq_valid2  input  1 each  fetch slot 1/2 holds an instruction.
REQ-008 Port: pcF1 / pcF2  input  32 each  PC of fetch slot 1/2.
REQ-009 Port: instrF1 / instrF2  input  32 each  instruction word of slot 1/2.
REQ-010 Port: enq_ready  output  1  at least 2 free entries; feeds the next-PC hold condition.
REQ-011 Port: deq_take  input  2  instructions decode consumes this cycle (0..2).
REQ-012 Port: validD1 / validD2  output  1 each  head / head+1 entry valid.
REQ-013 Port: pcD1 / pcD2, instrD1 / instrD2  output  32 each  head / head+1 entry contents.
REQ-014 Port: count  output  log2(DEPTH)+1  occupied entries.

Function
REQ-015 The queue SHALL be a circular buffer with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-016 enq_ready SHALL be 1 iff (DEPTH - count) >= 2, computed from the registered count only; a same-cycle dequeue does not raise it.
REQ-017 Enqueue SHALL occur only when enq_ready=1; slot 1 is written at tail and slot 2 at tail+1, in program order.
REQ-018 enq_valid2 with enq_valid1=0 SHALL be ignored; no entry is written.
REQ-019 Enqueue attempts while enq_ready=0 SHALL be dropped with no state change.
REQ-020 The effective dequeue SHALL be min(deq_take, number of valid outputs), so an over-request is clamped and never underflows.
REQ-021 The next count SHALL be count + accepted enqueues - effective dequeues; simultaneous enqueue and dequeue are legal.
REQ-022 validD1 SHALL be (count>=1) and validD2 SHALL be (count>=2); an output with valid low SHALL drive pc=RESET_PC and instr=32'h0000_0013 (NOP).
REQ-023 Without bypass, an enqueued instruction SHALL first appear on the D outputs one cycle after it is accepted.
REQ-024 When flush=1, count, head and tail SHALL be 0 on the next edge; same-cycle enqueue and dequeue are discarded.
REQ-025 While flush=1, validD1 and validD2 SHALL be forced low in the same cycle.

Reset
REQ-026 While rst=1, the block SHALL hold count=0, head=0, tail=0, enq_ready=1, validD1=validD2=0, pcD1=pcD2=RESET_PC and instrD1=instrD2=NOP.
REQ-027 Reset asserted mid-operation SHALL discard all entries, and storage contents SHALL NOT be observable afterwards.
REQ-028 On the first edge after rst deasserts, the block SHALL accept an enqueue.

Configuration
REQ-029 Macro FETCH_BUF_BYPASS_EN SHALL control empty-queue bypass of the D outputs.
REQ-030 With FETCH_BUF_BYPASS_EN defined, when count=0 and flush=0:
- slot 1 / slot 2 inputs drive the D outputs combinationally, with valids = enq_valid1 / (enq_valid1 & enq_valid2);
- entries dequeued that cycle are not written; only the remainder is stored.
REQ-031 Without FETCH_BUF_BYPASS_EN, the D outputs SHALL come only from storage, giving 1-cycle minimum latency per REQ-023.

Verification
REQ-032 Reset then enqueue pair (pc 0x10000/0x10004), deq_take=0 -> next cycle count=2, validD1=validD2=1, pcD1=0x10000, pcD2=0x10004.
REQ-033 Four pair enqueues with deq_take=0, DEPTH=8 -> count=8, enq_ready=0; a fifth enqueue is dropped and count stays 8.
REQ-034 Full queue, deq_take=2 with enqueue attempted the same cycle -> enqueue dropped, count=6, enq_ready=1 the following cycle.
REQ-035 count=3, enqueue pair plus deq_take=2 in one cycle -> count=3, order preserved across pointer wrap (run for 20+ cycles with random take, compare against a reference queue).
REQ-036 count=5, flush=1 with enqueue pair -> next cycle count=0, valids=0; with FETCH_BUF_BYPASS_EN on an empty queue, enqueue plus deq_take=2 -> D outputs show the inputs the same cycle and count stays 0.
REQ-037 Assert rst mid-stream with count=4 -> outputs take reset values immediately, asynchronously, without waiting for clk.
